// File: rtl/spi_sram_slave_pkg.sv
// Shared definitions for the SPI SRAM slave: opcodes, FSM states, mode reset value.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_sram_slave_pkg;

  // Serial SRAM command opcodes
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  // Mode register value after reset (sequential mode encoding)
  localparam logic [7:0] MODE_RST = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_MODE_RD,
    ST_MODE_WR,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_sram_slave.sv
// SPI serial-SRAM slave bridging a 1-bit SPI link (clk is the SPI clock) to a byte-wide sync RAM.
// Latency: read data leaves on miso at the clkb edge right after the last address bit; writes strobe one clk after each 8th bit.
// Backpressure: none on SPI; en/enb freeze the clk/clkb logic, cs_n high aborts at the next clk edge.
module spi_sram_slave
  import spi_sram_slave_pkg::*;
#(
  parameter int CS_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkb,
  input  logic        en,
  input  logic        enb,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  // Skip counter only has to reach CS_DELAY-1; keep it at least one bit wide.
  localparam int SKW = (CS_DELAY > 1) ? $clog2(CS_DELAY) : 1;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic           armed_q, armed_d;
  logic           is_rd_q, is_rd_d;
  logic [7:0]     sh_q, sh_d;
  logic [23:0]    addr_q, addr_d;
  logic [7:0]     mode_q, mode_d;
  logic           wr_pend_q, wr_pend_d;
  logic [7:0]     wbyte_q, wbyte_d;

  logic           miso_q;
  logic [6:0]     tx_q;
  logic           rd_first, rd_next;
  logic [7:0]     shin;

  assign shin = {sh_q[6:0], mosi};

  // clk-domain state register; armed_q blocks a new frame until cs_n has been seen high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      skip_q    <= '0;
      armed_q   <= 1'b0;
      is_rd_q   <= 1'b0;
      sh_q      <= '0;
      addr_q    <= '0;
      mode_q    <= MODE_RST;
      wr_pend_q <= 1'b0;
      wbyte_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      armed_q   <= armed_d;
      is_rd_q   <= is_rd_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      wr_pend_q <= wr_pend_d;
      wbyte_q   <= wbyte_d;
    end
  end

  // Next-state: one SPI bit per en-qualified clk edge while cs_n is low
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    armed_d   = armed_q;
    is_rd_d   = is_rd_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    wr_pend_d = wr_pend_q;
    wbyte_d   = wbyte_q;

    if (en) begin
      if (cs_n) begin
        // Abort; a write strobe shown this cycle has just been taken by the RAM.
        state_d   = ST_IDLE;
        cnt_d     = '0;
        skip_d    = '0;
        armed_d   = 1'b1;
        wr_pend_d = 1'b0;
      end else begin
        wr_pend_d = 1'b0;
        if (wr_pend_q) addr_d = addr_q + 24'd1;
        case (state_q)
          ST_IDLE: begin
            if (armed_q) begin
              if (CS_DELAY == 0) begin
                sh_d    = shin;
                cnt_d   = 5'd1;
                state_d = ST_CMD;
              end else if (CS_DELAY == 1) begin
                cnt_d   = '0;
                state_d = ST_CMD;
              end else begin
                skip_d  = SKW'(1);
                state_d = ST_SKIP;
              end
            end
          end
          ST_SKIP: begin
            if (skip_q == SKW'(CS_DELAY - 1)) begin
              cnt_d   = '0;
              state_d = ST_CMD;
            end else begin
              skip_d = skip_q + SKW'(1);
            end
          end
          ST_CMD: begin
            sh_d  = shin;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              case (shin)
                OP_READ:  begin state_d = ST_ADDR; is_rd_d = 1'b1; end
                OP_WRITE: begin state_d = ST_ADDR; is_rd_d = 1'b0; end
                OP_RDMR:  state_d = ST_MODE_RD;
                OP_WRMR:  state_d = ST_MODE_WR;
                default:  state_d = ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            addr_d = {addr_q[22:0], mosi};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d   = '0;
              state_d = is_rd_q ? ST_RDATA : ST_WDATA;
            end
          end
          ST_RDATA: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d  = '0;
              addr_d = addr_q + 24'd1;
            end
          end
          ST_WDATA: begin
            sh_d  = shin;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d     = '0;
              wbyte_d   = shin;
              wr_pend_d = 1'b1;
            end
          end
          ST_MODE_RD: begin
            cnt_d = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
          end
          ST_MODE_WR: begin
            sh_d  = shin;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d   = '0;
              mode_d  = shin;
              state_d = ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory strobes: read addresses are combinational so the RAM latches them on the same clk edge
  always_comb begin
    rd_first  = en & ~cs_n & (state_q == ST_ADDR) & (cnt_q == 5'd23) & is_rd_q;
    rd_next   = en & ~cs_n & (state_q == ST_RDATA) & (cnt_q == 5'd7);
    mem_en    = rd_first | rd_next | (en & wr_pend_q);
    mem_wr    = en & wr_pend_q;
    mem_wdata = wbyte_q;
    if (rd_first) begin
      mem_addr = {addr_q[22:0], mosi};
    end else if (rd_next) begin
      mem_addr = addr_q + 24'd1;
    end else begin
      mem_addr = addr_q;
    end
  end

  // miso launch on clkb: load bit 7 at the start of each output byte, then shift
  always_ff @(posedge clkb) begin
    if (rst) begin
      miso_q <= 1'b0;
      tx_q   <= '0;
    end else if (enb) begin
      if (state_q == ST_RDATA || state_q == ST_MODE_RD) begin
        if (cnt_q == 5'd0) begin
          miso_q <= (state_q == ST_MODE_RD) ? mode_q[7] : mem_rdata[7];
          tx_q   <= (state_q == ST_MODE_RD) ? mode_q[6:0] : mem_rdata[6:0];
        end else begin
          miso_q <= tx_q[6];
          tx_q   <= {tx_q[5:0], 1'b0};
        end
      end else begin
        miso_q <= 1'b0;
        tx_q   <= '0;
      end
    end
  end

  assign miso = miso_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed bench for spi_sram_slave: two instances (CS_DELAY 0 and 2) sharing one sync RAM model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_spi_sram_slave;

  logic              clk = 1'b0;
  logic              clkb;
  logic              rst, en, enb;
  logic [1:0]        cs_n, mosi, miso, mem_en, mem_wr;
  logic [1:0][23:0]  mem_addr;
  logic [1:0][7:0]   mem_wdata;
  logic [1:0][7:0]   mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [1:0]  s_en = '0;
  logic [1:0]  s_wr = '0;
  logic [1:0][23:0] s_addr = '0;
  logic [1:0][7:0]  s_wd = '0;
  int          stb_cnt [2] = '{0, 0};
  int          wr_cnt  [2] = '{0, 0};
  int          dbl_cnt [2] = '{0, 0};
  logic [23:0] aq0 [$];
  logic [7:0]  rbuf [4];

  always #5 clk = ~clk;
  assign clkb = ~clk;

  spi_sram_slave #(.CS_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .clkb(clkb), .en(en), .enb(enb),
    .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0]),
    .mem_addr(mem_addr[0]), .mem_en(mem_en[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  spi_sram_slave #(.CS_DELAY(2)) dut2 (
    .clk(clk), .rst(rst), .clkb(clkb), .en(en), .enb(enb),
    .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1]),
    .mem_addr(mem_addr[1]), .mem_en(mem_en[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i]) begin
        stb_cnt[i]++;
        if (mem_wr[i]) wr_cnt[i]++;
        if (s_en[i]) dbl_cnt[i]++;
      end
    end
    if (mem_en[0]) aq0.push_back(mem_addr[0]);
    s_en   = mem_en;
    s_wr   = mem_wr;
    s_addr = mem_addr;
    s_wd   = mem_wdata;
  end

  // Synchronous RAM: acts on the strobe seen during the cycle ending at this edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_en[i]) begin
        if (s_wr[i]) mem[s_addr[i]] = s_wd[i];
        else mem_rdata[i] <= mem_rd(s_addr[i]);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_x(input int d, input logic b, output logic r);
    mosi[d] = b;
    @(posedge clk);
    #1;
    r = miso[d];
  endtask

  task automatic byte_x(input int d, input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int k = 7; k >= 0; k--) begin
      bit_x(d, tx[k], r);
      rx[k] = r;
    end
  endtask

  task automatic spi_cmd(input int d, input int ndum, input logic [7:0] op, output logic [7:0] rx);
    logic r;
    cs_n[d] = 1'b0;
    for (int k = 0; k < ndum; k++) bit_x(d, 1'b0, r);
    byte_x(d, op, rx);
  endtask

  task automatic spi_addr(input int d, input logic [23:0] a);
    logic [7:0] rx;
    byte_x(d, a[23:16], rx);
    byte_x(d, a[15:8], rx);
    byte_x(d, a[7:0], rx);
  endtask

  task automatic spi_rd_bytes(input int d, input int nb);
    logic [7:0] rx;
    for (int k = 0; k < nb; k++) begin
      byte_x(d, 8'h00, rx);
      rbuf[k] = rx;
    end
  endtask

  task automatic cs_hi(input int d);
    cs_n[d] = 1'b1;
    mosi[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic r;
    int s0;
    rst = 1'b1; en = 1'b1; enb = 1'b1;
    cs_n = 2'b11; mosi = 2'b00;
    mem[24'h000202] = 8'h77;
    mem[24'hFFFFFF] = 8'hC3;
    mem[24'h000000] = 8'h18;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_miso0", {31'd0, miso[0]}, 32'd0);
    check_eq("rst_miso2", {31'd0, miso[1]}, 32'd0);
    check_eq("rst_mem_en", {31'd0, mem_en[0]}, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mem_wr[0]}, 32'd0);
    check_eq("rst_wdata", {24'd0, mem_wdata[0]}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // WRITE 0x200: A5, 5A
    s0 = stb_cnt[0];
    spi_cmd(0, 0, 8'h02, rx);
    spi_addr(0, 24'h000200);
    byte_x(0, 8'hA5, rx);
    byte_x(0, 8'h5A, rx);
    cs_hi(0);
    check_eq("wr_mem200", {24'd0, mem_rd(24'h000200)}, 32'hA5);
    check_eq("wr_mem201", {24'd0, mem_rd(24'h000201)}, 32'h5A);
    check_eq("wr_strobes", wr_cnt[0], 32'd2);
    check_eq("wr_stb_total", stb_cnt[0] - s0, 32'd2);

    // READ 0x200, three bytes
    s0 = stb_cnt[0];
    spi_cmd(0, 0, 8'h03, rx);
    check_eq("rd_cmd_miso", {24'd0, rx}, 32'h00);
    spi_addr(0, 24'h000200);
    spi_rd_bytes(0, 3);
    cs_hi(0);
    check_eq("rd_b0", {24'd0, rbuf[0]}, 32'hA5);
    check_eq("rd_b1", {24'd0, rbuf[1]}, 32'h5A);
    check_eq("rd_b2", {24'd0, rbuf[2]}, 32'h77);
    check_eq("rd_stb", stb_cnt[0] - s0, 32'd4);

    // READ across the top of the address space
    aq0.delete();
    spi_cmd(0, 0, 8'h03, rx);
    spi_addr(0, 24'hFFFFFF);
    spi_rd_bytes(0, 2);
    cs_hi(0);
    check_eq("wrap_b0", {24'd0, rbuf[0]}, 32'hC3);
    check_eq("wrap_b1", {24'd0, rbuf[1]}, 32'h18);
    check_eq("wrap_nstb", aq0.size(), 32'd3);
    check_eq("wrap_addr0", (aq0.size() > 0) ? {8'd0, aq0[0]} : 32'hDEAD, 32'hFFFFFF);
    check_eq("wrap_addr1", (aq0.size() > 1) ? {8'd0, aq0[1]} : 32'hDEAD, 32'h000000);

    // Mode register
    s0 = stb_cnt[0];
    spi_cmd(0, 0, 8'h05, rx);
    spi_rd_bytes(0, 2);
    cs_hi(0);
    check_eq("rdmr_rst_a", {24'd0, rbuf[0]}, 32'h40);
    check_eq("rdmr_rst_b", {24'd0, rbuf[1]}, 32'h40);
    spi_cmd(0, 0, 8'h01, rx);
    byte_x(0, 8'h00, rx);
    cs_hi(0);
    spi_cmd(0, 0, 8'h05, rx);
    spi_rd_bytes(0, 1);
    cs_hi(0);
    check_eq("rdmr_00", {24'd0, rbuf[0]}, 32'h00);
    spi_cmd(0, 0, 8'h01, rx);
    byte_x(0, 8'h5C, rx);
    cs_hi(0);
    spi_cmd(0, 0, 8'h05, rx);
    spi_rd_bytes(0, 2);
    cs_hi(0);
    check_eq("rdmr_5c_a", {24'd0, rbuf[0]}, 32'h5C);
    check_eq("rdmr_5c_b", {24'd0, rbuf[1]}, 32'h5C);
    check_eq("mode_no_stb", stb_cnt[0] - s0, 32'd0);

    // Partial write byte is dropped
    s0 = stb_cnt[0];
    spi_cmd(0, 0, 8'h02, rx);
    spi_addr(0, 24'h000300);
    bit_x(0, 1'b1, r);
    bit_x(0, 1'b0, r);
    bit_x(0, 1'b1, r);
    bit_x(0, 1'b1, r);
    cs_hi(0);
    check_eq("partial_stb", stb_cnt[0] - s0, 32'd0);
    check_eq("partial_mem", {31'd0, mem.exists(24'h000300)}, 32'd0);
    spi_cmd(0, 0, 8'h03, rx);
    spi_addr(0, 24'h000200);
    spi_rd_bytes(0, 1);
    cs_hi(0);
    check_eq("post_partial_rd", {24'd0, rbuf[0]}, 32'hA5);

    // CS_DELAY=2 instance: two leading dummy clocks
    s0 = stb_cnt[1];
    spi_cmd(1, 2, 8'h03, rx);
    spi_addr(1, 24'h000200);
    spi_rd_bytes(1, 3);
    cs_hi(1);
    check_eq("dly_b0", {24'd0, rbuf[0]}, 32'hA5);
    check_eq("dly_b1", {24'd0, rbuf[1]}, 32'h5A);
    check_eq("dly_b2", {24'd0, rbuf[2]}, 32'h77);
    check_eq("dly_stb", stb_cnt[1] - s0, 32'd4);
    s0 = stb_cnt[1];
    spi_cmd(1, 2, 8'hFF, rx);
    check_eq("ign_cmd_miso", {24'd0, rx}, 32'h00);
    spi_rd_bytes(1, 2);
    cs_hi(1);
    check_eq("ign_b0", {24'd0, rbuf[0]}, 32'h00);
    check_eq("ign_b1", {24'd0, rbuf[1]}, 32'h00);
    check_eq("ign_stb", stb_cnt[1] - s0, 32'd0);

    // Reset mid-transaction: rest of the frame is ignored until cs_n toggles
    s0 = stb_cnt[0];
    spi_cmd(0, 0, 8'h03, rx);
    byte_x(0, 8'h00, rx);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    byte_x(0, 8'h02, rx);
    spi_addr(0, 24'h000200);
    byte_x(0, 8'h3C, rx);
    cs_hi(0);
    check_eq("rst_mid_stb", stb_cnt[0] - s0, 32'd0);
    check_eq("rst_mid_mem", {24'd0, mem_rd(24'h000200)}, 32'hA5);
    spi_cmd(0, 0, 8'h03, rx);
    spi_addr(0, 24'h000201);
    spi_rd_bytes(0, 1);
    cs_hi(0);
    check_eq("post_rst_rd", {24'd0, rbuf[0]}, 32'h5A);

    check_eq("dbl_stb0", dbl_cnt[0], 32'd0);
    check_eq("dbl_stb2", dbl_cnt[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
